lc3b_control: RTL and testbench
===============================

Name: lc3b_control

Overview:
- Multicycle control FSM for the LC-3b datapath.
- Consumes the decoded instruction-register fields (opcode, ir11, imm-select bit, A/D bits) plus the branch-enable and memory-response signals.
- Drives every datapath load enable, mux select, ALU op and memory strobe.
- Sequences fetch, decode and execute for all 16 opcodes, with an optional memory-response watchdog.

Parameters:
- MEM_TIMEOUT, default 0: max cycles to wait for mem_resp in any memory state; 0 disables the watchdog.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- opcode  input  4  IR[15:12]
- ir11  input  1  IR[11] (JSR vs JSRR)
- ir5  input  1  IR[5] (imm/reg select, SHF A-bit)
- ir4  input  1  IR[4] (SHF D-bit)
- branch_enable  input  1  NZP-vs-CC match
- mem_resp  input  1  memory done, single-cycle pulse
- mar0  input  1  MAR[0], byte lane for LDB/STB
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  output  1 each  register enables
- pcmux_sel  output  2  0 PC+2, 1 adder, 2 base reg (JMP/JSRR), 3 MDR (TRAP)
- marmux_sel  output  2  0 adder, 1 PC, 2 zext(trapvect8)<<1, 3 MDR (LDI/STI)
- adjmux_sel  output  2  0 sext(offset6)<<1, 1 sext(offset9)<<1, 2 sext(offset11)<<1, 3 zext(offset6) byte
- regfilemux_sel  output  3  0 ALU, 1 MDR, 2 PC, 3 adder, 4 zext(MDR byte)
- alumux_sel  output  2  0 reg, 1 sext(imm5), 2 imm4
- aluop  output  3  0 ADD, 1 AND, 2 NOT, 3 PASS, 4 SLL, 5 SRL, 6 SRA
- mdrmux_sel, storemux_sel, destmux_sel  output  1 each  MDR from mem/ALU; SR1 from src1/dest; dest from IR/R7
- mem_read, mem_write  output  1 each  memory strobes
- mem_byte_enable  output  2  write byte lanes
- err  output  1  sticky watchdog error

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to FETCH1 and the watchdog counter clears.
  - Reset overrides any state, including a mem-wait state mid-access.
  - No memory strobe is asserted in the cycle after reset.
- Output defaults: all outputs are 0 in every state unless asserted below (Moore). mem_byte_enable defaults to 2'b11.
- FETCH1:
  - load_mar, marmux=1.
  - load_pc, pcmux=0.
  - -> FETCH2.
- FETCH2: mem_read, load_mdr held; stays until mem_resp=1, then -> FETCH3.
- FETCH3: load_ir; -> DECODE.
- DECODE: no outputs; dispatch on opcode.
- Single-cycle execute states, each -> FETCH1:
  - ADD/AND/NOT: load_regfile, load_cc, aluop per op, alumux=ir5.
  - SHF: aluop SLL if ir4=0; otherwise SRL if ir5=0, SRA if ir5=1. alumux=2, load_regfile, load_cc.
  - LEA: adjmux=1, regfilemux=3, load_regfile, load_cc.
  - BR: if branch_enable, load_pc, pcmux=1, adjmux=1; else no action.
  - JMP: load_pc, pcmux=2.
  - RTI: treated as NOP.
- JSR (two states):
  - JSR1: destmux=1, regfilemux=2, load_regfile.
  - JSR2: load_pc with pcmux=1/adjmux=2 if ir11, else pcmux=2.
- LDR/LDB:
  - CALC_ADDR: load_mar, marmux=0, adjmux=0 (LDR) or 3 (LDB).
  - MEM_RD: mem_read+load_mdr until mem_resp.
  - WB: load_regfile, load_cc, regfilemux=1 (LDR) or 4 (LDB, byte from mar0).
- STR/STB:
  - CALC_ADDR.
  - ST_DATA: storemux=1, aluop=PASS, mdrmux=1, load_mdr.
  - MEM_WR: mem_write until mem_resp. STB byte_enable = mar0 ? 2'b10 : 2'b01.
- LDI/STI: CALC_ADDR, MEM_RD, INDIR (load_mar, marmux=3), then the LDR-style or STR-style tail.
- TRAP:
  - TRAP1: destmux=1, regfilemux=2, load_regfile.
  - TRAP2: load_mar, marmux=2.
  - MEM_RD.
  - TRAP3: load_pc, pcmux=3.
- mem_resp in a non-memory state is ignored.
- Watchdog (MEM_TIMEOUT>0):
  - Counter increments each cycle in a mem-wait state and clears on leaving it.
  - If it reaches MEM_TIMEOUT without mem_resp -> ERROR.
  - ERROR: all outputs 0, err=1, held until reset.

Test Plan:
- Reset, then release with mem_resp tied high → cycle 1: load_mar=1, marmux=1, load_pc=1. Cycle 2: mem_read=1. Cycle 3: load_ir=1. No strobe during reset.
- ADD imm (opcode 0001, ir5=1) with 1-cycle mem_resp → execute state has load_regfile=1, load_cc=1, aluop=0, alumux=1. Back to FETCH1 5 cycles after the first FETCH1.
- STB with mar0=1, mem_resp delayed 3 cycles → mem_write=1 and byte_enable=2'b10 held for exactly 3 cycles. Then FETCH1.
- BR with branch_enable=0 → load_pc=0 in BR state. Repeat with branch_enable=1 → load_pc=1, pcmux=1, adjmux=1.
- TRAP → TRAP1 writes R7 (destmux=1, regfilemux=2). marmux=2, then pcmux=3 after mem_resp.
- MEM_TIMEOUT=4, mem_resp never asserted in FETCH2 → err=1 on cycle 5 of FETCH2, all strobes 0. rst_n=0 for one edge → FETCH1, err=0.

Source files
------------

// File: rtl/lc3b_control_if.sv
// Control bundle between the LC-3b multicycle controller and its datapath.
// The controller side (master) consumes decoded IR fields and memory status and drives every enable/select.
interface lc3b_control_if;
    logic [3:0] opcode;
    logic       ir11;
    logic       ir5;
    logic       ir4;
    logic       branch_enable;
    logic       mem_resp;
    logic       mar0;

    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic [1:0] pcmux_sel;
    logic [1:0] marmux_sel;
    logic [1:0] adjmux_sel;
    logic [2:0] regfilemux_sel;
    logic [1:0] alumux_sel;
    logic [2:0] aluop;
    logic       mdrmux_sel;
    logic       storemux_sel;
    logic       destmux_sel;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
    logic       err;

    modport master (
        input  opcode, ir11, ir5, ir4, branch_enable, mem_resp, mar0,
        output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
               pcmux_sel, marmux_sel, adjmux_sel, regfilemux_sel, alumux_sel, aluop,
               mdrmux_sel, storemux_sel, destmux_sel, mem_read, mem_write,
               mem_byte_enable, err
    );

    modport slave (
        output opcode, ir11, ir5, ir4, branch_enable, mem_resp, mar0,
        input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
               pcmux_sel, marmux_sel, adjmux_sel, regfilemux_sel, alumux_sel, aluop,
               mdrmux_sel, storemux_sel, destmux_sel, mem_read, mem_write,
               mem_byte_enable, err
    );
endinterface

// File: rtl/lc3b_control.sv
// Multicycle Moore control FSM for the LC-3b datapath, with an optional memory-response watchdog.
//
//   state       | meaning
//   S_FETCH1    | MAR <- PC, PC <- PC+2
//   S_FETCH2    | instruction read, wait for mem_resp
//   S_FETCH3    | IR <- MDR
//   S_DECODE    | dispatch on opcode
//   S_ADD/AND/NOT/SHF/LEA | single-cycle ALU / address write-back
//   S_BR, S_JMP | PC update (BR only when branch taken)
//   S_NOP       | RTI, no action
//   S_JSR1/2    | R7 <- PC, then PC <- PC+off11 or base reg
//   S_CALC_ADDR | MAR <- base + offset for loads/stores
//   S_IND_RD    | pointer read for LDI/STI
//   S_INDIR     | MAR <- MDR
//   S_MEM_RD    | data read (loads, TRAP vector)
//   S_LD_WB     | register write-back from MDR
//   S_ST_DATA   | MDR <- store source register
//   S_MEM_WR    | data write, wait for mem_resp
//   S_TRAP1/2/3 | R7 <- PC, MAR <- trapvect, PC <- MDR
//   S_ERROR     | watchdog expired, everything off until reset
module lc3b_control #(
    parameter int MEM_TIMEOUT = 0
) (
    input logic            clk,
    input logic            rst_n,
    lc3b_control_if.master bus
);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_SHF, S_LEA, S_BR, S_JMP, S_NOP,
        S_JSR1, S_JSR2,
        S_CALC_ADDR, S_IND_RD, S_INDIR, S_MEM_RD, S_LD_WB,
        S_ST_DATA, S_MEM_WR,
        S_TRAP1, S_TRAP2, S_TRAP3,
        S_ERROR
    } state_t;

    state_t          state, next_state;
    logic [WD_W-1:0] wd_cnt;
    logic            mem_wait;
    logic            wd_expired;
    logic            is_byte;

    assign mem_wait   = (state == S_FETCH2) || (state == S_IND_RD) ||
                        (state == S_MEM_RD) || (state == S_MEM_WR);
    // Down-counter reaches terminal count on the MEM_TIMEOUT-th wait cycle.
    assign wd_expired = (MEM_TIMEOUT > 0) && (wd_cnt == '0) && !bus.mem_resp;
    assign is_byte    = (bus.opcode == OP_LDB) || (bus.opcode == OP_STB);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_FETCH1;
            wd_cnt <= WD_LOAD;
        end else begin
            state <= next_state;
            if (mem_wait && (next_state == state))
                wd_cnt <= wd_cnt - WD_W'(1);
            else
                wd_cnt <= WD_LOAD;
        end
    end

    always_comb begin
        next_state          = state;
        bus.load_pc         = 1'b0;
        bus.load_ir         = 1'b0;
        bus.load_regfile    = 1'b0;
        bus.load_mar        = 1'b0;
        bus.load_mdr        = 1'b0;
        bus.load_cc         = 1'b0;
        bus.pcmux_sel       = 2'd0;
        bus.marmux_sel      = 2'd0;
        bus.adjmux_sel      = 2'd0;
        bus.regfilemux_sel  = 3'd0;
        bus.alumux_sel      = 2'd0;
        bus.aluop           = 3'd0;
        bus.mdrmux_sel      = 1'b0;
        bus.storemux_sel    = 1'b0;
        bus.destmux_sel     = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b11;
        bus.err             = 1'b0;

        case (state)
            S_FETCH1: begin
                bus.load_mar   = 1'b1;
                bus.marmux_sel = 2'd1;
                bus.load_pc    = 1'b1;
                next_state     = S_FETCH2;
            end
            S_FETCH2: begin
                bus.mem_read = 1'b1;
                bus.load_mdr = 1'b1;
                if (bus.mem_resp)   next_state = S_FETCH3;
                else if (wd_expired) next_state = S_ERROR;
            end
            S_FETCH3: begin
                bus.load_ir = 1'b1;
                next_state  = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_BR:   next_state = S_BR;
                    OP_ADD:  next_state = S_ADD;
                    OP_AND:  next_state = S_AND;
                    OP_NOT:  next_state = S_NOT;
                    OP_SHF:  next_state = S_SHF;
                    OP_LEA:  next_state = S_LEA;
                    OP_JMP:  next_state = S_JMP;
                    OP_RTI:  next_state = S_NOP;
                    OP_JSR:  next_state = S_JSR1;
                    OP_TRAP: next_state = S_TRAP1;
                    default: next_state = S_CALC_ADDR;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                bus.load_regfile = 1'b1;
                bus.load_cc      = 1'b1;
                bus.alumux_sel   = {1'b0, bus.ir5};
                bus.aluop        = (state == S_ADD) ? 3'd0 : (state == S_AND) ? 3'd1 : 3'd2;
                next_state       = S_FETCH1;
            end
            S_SHF: begin
                bus.load_regfile = 1'b1;
                bus.load_cc      = 1'b1;
                bus.alumux_sel   = 2'd2;
                bus.aluop        = !bus.ir4 ? 3'd4 : (bus.ir5 ? 3'd6 : 3'd5);
                next_state       = S_FETCH1;
            end
            S_LEA: begin
                bus.adjmux_sel     = 2'd1;
                bus.regfilemux_sel = 3'd3;
                bus.load_regfile   = 1'b1;
                bus.load_cc        = 1'b1;
                next_state         = S_FETCH1;
            end
            S_BR: begin
                if (bus.branch_enable) begin
                    bus.load_pc    = 1'b1;
                    bus.pcmux_sel  = 2'd1;
                    bus.adjmux_sel = 2'd1;
                end
                next_state = S_FETCH1;
            end
            S_JMP: begin
                bus.load_pc   = 1'b1;
                bus.pcmux_sel = 2'd2;
                next_state    = S_FETCH1;
            end
            S_NOP: next_state = S_FETCH1;
            S_JSR1, S_TRAP1: begin
                bus.destmux_sel    = 1'b1;
                bus.regfilemux_sel = 3'd2;
                bus.load_regfile   = 1'b1;
                next_state         = (state == S_JSR1) ? S_JSR2 : S_TRAP2;
            end
            S_JSR2: begin
                bus.load_pc = 1'b1;
                if (bus.ir11) begin
                    bus.pcmux_sel  = 2'd1;
                    bus.adjmux_sel = 2'd2;
                end else begin
                    bus.pcmux_sel  = 2'd2;
                end
                next_state = S_FETCH1;
            end
            S_CALC_ADDR: begin
                bus.load_mar   = 1'b1;
                bus.adjmux_sel = is_byte ? 2'd3 : 2'd0;
                if ((bus.opcode == OP_LDI) || (bus.opcode == OP_STI)) next_state = S_IND_RD;
                else if ((bus.opcode == OP_LDR) || (bus.opcode == OP_LDB)) next_state = S_MEM_RD;
                else next_state = S_ST_DATA;
            end
            S_IND_RD: begin
                bus.mem_read = 1'b1;
                bus.load_mdr = 1'b1;
                if (bus.mem_resp)   next_state = S_INDIR;
                else if (wd_expired) next_state = S_ERROR;
            end
            S_INDIR: begin
                bus.load_mar   = 1'b1;
                bus.marmux_sel = 2'd3;
                next_state     = (bus.opcode == OP_LDI) ? S_MEM_RD : S_ST_DATA;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.load_mdr = 1'b1;
                if (bus.mem_resp)   next_state = (bus.opcode == OP_TRAP) ? S_TRAP3 : S_LD_WB;
                else if (wd_expired) next_state = S_ERROR;
            end
            S_LD_WB: begin
                bus.load_regfile   = 1'b1;
                bus.load_cc        = 1'b1;
                bus.regfilemux_sel = (bus.opcode == OP_LDB) ? 3'd4 : 3'd1;
                next_state         = S_FETCH1;
            end
            S_ST_DATA: begin
                bus.storemux_sel = 1'b1;
                bus.aluop        = 3'd3;
                bus.mdrmux_sel   = 1'b1;
                bus.load_mdr     = 1'b1;
                next_state       = S_MEM_WR;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                if (bus.opcode == OP_STB)
                    bus.mem_byte_enable = bus.mar0 ? 2'b10 : 2'b01;
                if (bus.mem_resp)   next_state = S_FETCH1;
                else if (wd_expired) next_state = S_ERROR;
            end
            S_TRAP2: begin
                bus.load_mar   = 1'b1;
                bus.marmux_sel = 2'd2;
                next_state     = S_MEM_RD;
            end
            S_TRAP3: begin
                bus.load_pc   = 1'b1;
                bus.pcmux_sel = 2'd3;
                next_state    = S_FETCH1;
            end
            S_ERROR: begin
                bus.mem_byte_enable = 2'b00;
                bus.err             = 1'b1;
            end
            default: next_state = S_FETCH1;
        endcase
    end

endmodule

// File: tb/tb_lc3b_control.sv
// Randomized bench for lc3b_control: a per-instruction cycle script built from the ISA rules is compared every cycle.
module tb_lc3b_control;

    typedef struct packed {
        logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
        logic [1:0] pcmux, marmux, adjmux;
        logic [2:0] rfmux;
        logic [1:0] alumux;
        logic [2:0] aluop;
        logic       mdrmux, storemux, destmux, mem_read, mem_write;
        logic [1:0] be;
        logic       err;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       ir11 = 1'b0, ir5 = 1'b0, ir4 = 1'b0;
    logic       branch_enable = 1'b0, mem_resp = 1'b0, mar0 = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    ctl_t  exp_q[$];
    bit    resp_q[$];
    string tag_q[$];

    lc3b_control_if if_wd ();
    lc3b_control_if if_nw ();

    lc3b_control #(.MEM_TIMEOUT(4)) dut_wd (.clk(clk), .rst_n(rst_n), .bus(if_wd));
    lc3b_control #(.MEM_TIMEOUT(0)) dut_nw (.clk(clk), .rst_n(rst_n), .bus(if_nw));

    assign if_wd.opcode = opcode;        assign if_nw.opcode = opcode;
    assign if_wd.ir11 = ir11;            assign if_nw.ir11 = ir11;
    assign if_wd.ir5 = ir5;              assign if_nw.ir5 = ir5;
    assign if_wd.ir4 = ir4;              assign if_nw.ir4 = ir4;
    assign if_wd.branch_enable = branch_enable;
    assign if_nw.branch_enable = branch_enable;
    assign if_wd.mem_resp = mem_resp;    assign if_nw.mem_resp = mem_resp;
    assign if_wd.mar0 = mar0;            assign if_nw.mar0 = mar0;

    ctl_t obs_wd, obs_nw;
    assign obs_wd = {if_wd.load_pc, if_wd.load_ir, if_wd.load_regfile, if_wd.load_mar, if_wd.load_mdr,
                     if_wd.load_cc, if_wd.pcmux_sel, if_wd.marmux_sel, if_wd.adjmux_sel,
                     if_wd.regfilemux_sel, if_wd.alumux_sel, if_wd.aluop, if_wd.mdrmux_sel,
                     if_wd.storemux_sel, if_wd.destmux_sel, if_wd.mem_read, if_wd.mem_write,
                     if_wd.mem_byte_enable, if_wd.err};
    assign obs_nw = {if_nw.load_pc, if_nw.load_ir, if_nw.load_regfile, if_nw.load_mar, if_nw.load_mdr,
                     if_nw.load_cc, if_nw.pcmux_sel, if_nw.marmux_sel, if_nw.adjmux_sel,
                     if_nw.regfilemux_sel, if_nw.alumux_sel, if_nw.aluop, if_nw.mdrmux_sel,
                     if_nw.storemux_sel, if_nw.destmux_sel, if_nw.mem_read, if_nw.mem_write,
                     if_nw.mem_byte_enable, if_nw.err};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input ctl_t got, input ctl_t exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.be = 2'b11;
        return c;
    endfunction

    task automatic push(input string tag, input ctl_t c);
        exp_q.push_back(c);
        resp_q.push_back(1'($urandom_range(0, 1)));
        tag_q.push_back(tag);
    endtask

    task automatic push_wait(input string tag, input ctl_t c, input int lat);
        for (int i = 1; i <= lat; i++) begin
            exp_q.push_back(c);
            resp_q.push_back(i == lat);
            tag_q.push_back(tag);
        end
    endtask

    function automatic ctl_t w_fetch1();
        ctl_t c = idle();
        c.load_mar = 1; c.marmux = 1; c.load_pc = 1; c.pcmux = 0;
        return c;
    endfunction

    function automatic ctl_t w_read();
        ctl_t c = idle();
        c.mem_read = 1; c.load_mdr = 1;
        return c;
    endfunction

    function automatic int pick_lat(input int fixed);
        return (fixed > 0) ? fixed : int'($urandom_range(1, 4));
    endfunction

    // Expected per-cycle controls for one whole instruction, fetch included.
    task automatic build(input logic [3:0] op, input int lat);
        ctl_t c;
        bit is_ld, is_st;
        push("fetch1", w_fetch1());
        push_wait("fetch2", w_read(), pick_lat(lat));
        c = idle(); c.load_ir = 1; push("fetch3", c);
        push("decode", idle());
        is_ld = (op == 4'b0110) || (op == 4'b0010) || (op == 4'b1010);
        is_st = (op == 4'b0111) || (op == 4'b0011) || (op == 4'b1011);
        if (op == 4'b0001 || op == 4'b0101 || op == 4'b1001) begin
            c = idle(); c.load_regfile = 1; c.load_cc = 1; c.alumux = {1'b0, ir5};
            c.aluop = (op == 4'b0001) ? 3'd0 : (op == 4'b0101) ? 3'd1 : 3'd2;
            push("alu", c);
        end else if (op == 4'b1101) begin
            c = idle(); c.load_regfile = 1; c.load_cc = 1; c.alumux = 2;
            c.aluop = (ir4 == 0) ? 3'd4 : (ir5 ? 3'd6 : 3'd5);
            push("shf", c);
        end else if (op == 4'b1110) begin
            c = idle(); c.adjmux = 1; c.rfmux = 3; c.load_regfile = 1; c.load_cc = 1;
            push("lea", c);
        end else if (op == 4'b0000) begin
            c = idle();
            if (branch_enable) begin c.load_pc = 1; c.pcmux = 1; c.adjmux = 1; end
            push("br", c);
        end else if (op == 4'b1100) begin
            c = idle(); c.load_pc = 1; c.pcmux = 2; push("jmp", c);
        end else if (op == 4'b1000) begin
            push("rti", idle());
        end else if (op == 4'b0100) begin
            c = idle(); c.destmux = 1; c.rfmux = 2; c.load_regfile = 1; push("jsr1", c);
            c = idle(); c.load_pc = 1;
            if (ir11) begin c.pcmux = 1; c.adjmux = 2; end else c.pcmux = 2;
            push("jsr2", c);
        end else if (op == 4'b1111) begin
            c = idle(); c.destmux = 1; c.rfmux = 2; c.load_regfile = 1; push("trap1", c);
            c = idle(); c.load_mar = 1; c.marmux = 2; push("trap2", c);
            push_wait("trap_rd", w_read(), pick_lat(lat));
            c = idle(); c.load_pc = 1; c.pcmux = 3; push("trap3", c);
        end else if (is_ld || is_st) begin
            c = idle(); c.load_mar = 1; c.marmux = 0;
            c.adjmux = (op == 4'b0010 || op == 4'b0011) ? 2'd3 : 2'd0;
            push("calc", c);
            if (op == 4'b1010 || op == 4'b1011) begin
                push_wait("ind_rd", w_read(), pick_lat(lat));
                c = idle(); c.load_mar = 1; c.marmux = 3; push("indir", c);
            end
            if (is_ld) begin
                push_wait("ld_rd", w_read(), pick_lat(lat));
                c = idle(); c.load_regfile = 1; c.load_cc = 1;
                c.rfmux = (op == 4'b0010) ? 3'd4 : 3'd1;
                push("ld_wb", c);
            end else begin
                c = idle(); c.storemux = 1; c.aluop = 3; c.mdrmux = 1; c.load_mdr = 1;
                push("st_data", c);
                c = idle(); c.mem_write = 1;
                if (op == 4'b0011) c.be = mar0 ? 2'b10 : 2'b01;
                push_wait("st_wr", c, pick_lat(lat));
            end
        end
    endtask

    task automatic run_queue();
        while (exp_q.size() > 0) begin
            ctl_t  e = exp_q.pop_front();
            string t = tag_q.pop_front();
            mem_resp = resp_q.pop_front();
            #1;
            chk({t, "/wd"}, obs_wd, e);
            chk({t, "/nw"}, obs_nw, e);
            @(posedge clk); #1;
        end
        mem_resp = 1'b0;
    endtask

    task automatic do_instr(input logic [3:0] op, input logic i11, input logic i5, input logic i4,
                            input logic be, input logic m0, input int lat);
        opcode = op; ir11 = i11; ir5 = i5; ir4 = i4; branch_enable = be; mar0 = m0;
        build(op, lat);
        run_queue();
    endtask

    task automatic do_random(input int n);
        for (int i = 0; i < n; i++)
            do_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 0);
    endtask

    initial begin
        ctl_t c_err;
        // Reset with mem_resp high: the first post-reset state must be fetch with no strobe.
        rst_n = 1'b0; mem_resp = 1'b1; opcode = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset/wd", obs_wd, w_fetch1());
            chk("reset/nw", obs_nw, w_fetch1());
        end
        rst_n = 1'b1;

        do_instr(4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);  // ADD imm, 1-cycle memory
        do_instr(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);  // STB high byte, 3-cycle write
        do_instr(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);  // STB low byte
        do_instr(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);  // BR not taken
        do_instr(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);  // BR taken
        do_instr(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);  // TRAP
        do_instr(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);  // LDI at watchdog limit
        do_instr(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);  // STI at watchdog limit
        do_instr(4'b1101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1);  // SHF SRA
        do_instr(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);  // JSR
        do_random(60);

        // Watchdog: fetch read never answered.
        mem_resp = 1'b0;
        chk("to_f1/wd", obs_wd, w_fetch1());
        chk("to_f1/nw", obs_nw, w_fetch1());
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
            chk("to_wait/wd", obs_wd, w_read());
            chk("to_wait/nw", obs_nw, w_read());
            @(posedge clk); #1;
        end
        c_err = '0; c_err.err = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("to_err/wd", obs_wd, c_err);
            chk("to_nowd/nw", obs_nw, w_read());
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("to_reset/wd", obs_wd, w_fetch1());
        chk("to_reset/nw", obs_nw, w_fetch1());

        do_random(20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
